fifo_uart_tx: RTL and testbench

Downstream drain stage for the 256x8 single-clock FIFO (the scfifo_256x8 wrapper). Whenever the FIFO is non-empty, it pops one byte and serialises it on a UART 8N1 line, LSB first. It then returns to fetch the next byte. It shares sys_clk with the FIFO and is that FIFO's only reader.

---
 rtl/fifo_uart_tx_if.sv | 28 ++
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side handshake between a normal-mode (non-show-ahead) single-clock FIFO
// and its sole reader.
//   fifo_empty : FIFO -> reader, FIFO empty flag
//   fifo_q     : FIFO -> reader, read data, valid the cycle after fifo_rdreq
//   fifo_rdreq : reader -> FIFO, one-cycle read request per byte
// Modports:
//   master : the reader (drives fifo_rdreq)
//   slave  : the FIFO   (drives fifo_empty and fifo_q)
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_q;
    logic       fifo_rdreq;

    modport master (
        input  fifo_empty,
        input  fifo_q,
        output fifo_rdreq
    );

    modport slave (
        output fifo_empty,
        output fifo_q,
        input  fifo_rdreq
    );
endinterface : fifo_uart_tx_if

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains a 256x8 single-clock FIFO and serialises each byte as UART 8N1,
// LSB first. Pops one byte whenever the FIFO is non-empty and the line is idle.
// Ports:
//   sys_clk : system clock, all logic on the rising edge
//   sys_rst : synchronous, active-high reset
//   fifo    : FIFO read handshake (master side: fifo_rdreq out, empty/q in)
//   tx      : registered UART serial output, idle high
//   busy    : registered, high in every state except IDLE
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy
);
    localparam int              CNT_W    = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FETCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             rdreq_q, rdreq_d;
    logic             busy_q, busy_d;
    logic             wrap_s;

    // Next-state logic for the framing FSM and its baud/bit counters.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        wrap_s    = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                // fifo_empty is only looked at here, so a pop can never be
                // requested from an empty FIFO.
                if (!fifo.fifo_empty) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                state_d = FETCH;
            end
            FETCH: begin
                // Normal-mode FIFO: data requested in REQ is valid now.
                shift_d = fifo.fifo_q;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (wrap_s) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (wrap_s) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (wrap_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // Output values are decoded from the next state so that the registered
    // outputs line up with the state they belong to, with no extra latency.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        rdreq_d = (state_d == REQ);
        busy_d  = (state_d != IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            rdreq_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rdreq_q   <= rdreq_d;
            busy_q    <= busy_d;
        end
    end

    assign tx              = tx_q;
    assign busy            = busy_q;
    assign fifo.fifo_rdreq = rdreq_q;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx. A small FIFO model feeds the main instance
// (BAUD_CNT_MAX = 4); bytes written to the model are also pushed to a
// scoreboard and popped when the decoded frame appears on tx. A second
// instance at the default 9600 baud checks the long bit timing.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;
    logic sys_clk = 1'b0;
    logic sys_rst;
    logic tx, busy, tx2, busy2;

    fifo_uart_tx_if if1();
    fifo_uart_tx_if if2();

    always #5 sys_clk = ~sys_clk;

    fifo_uart_tx #(.CLK_FREQ(50_000_000), .BAUD(12_500_000)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .fifo    (if1),
        .tx      (tx),
        .busy    (busy)
    );

    fifo_uart_tx #(.CLK_FREQ(50_000_000), .BAUD(9600)) dut_def (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .fifo    (if2),
        .tx      (tx2),
        .busy    (busy2)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, data, start}, bit 0 sent first
        int         gap;     // high cycles seen before this start bit
    } vec_t;

    vec_t       vecs [3];
    int         n_cmp, n_err;
    int         n_rd, n_busy;
    logic [7:0] mq [$];      // FIFO model contents
    logic [7:0] sb_q [$];    // scoreboard of expected bytes

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge and update the FIFO models.
    task automatic tick();
        @(negedge sys_clk);
        if (if1.fifo_rdreq === 1'b1) begin
            n_rd++;
            chk("rdreq_nonempty", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) if1.fifo_q = mq.pop_front();
        end
        if1.fifo_empty = (mq.size() == 0);
        if (busy === 1'b1) n_busy++;
        if (if2.fifo_rdreq === 1'b1) if2.fifo_empty = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        mq.push_back(d);
        sb_q.push_back(d);
        if1.fifo_empty = 1'b0;
    endtask

    // Advance until tx is low; n = number of high cycles passed.
    task automatic wait_start(output int n, input string name);
        n = 0;
        tick();
        while (tx !== 1'b0 && n < 200) begin
            n++;
            tick();
        end
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no start bit, required one within 200 cycles", name);
        end
    endtask

    // Current cycle is the first start-bit cycle; capture 40 cycles.
    task automatic run_frame(input logic [9:0] exp_f, input string name);
        logic [9:0] got;
        logic [7:0] e;
        int         glitch;
        got    = 10'd0;
        glitch = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick();
            if (k % 4 == 0) got[k / 4] = tx;
            else if (tx !== got[k / 4]) glitch++;
        end
        chk({name, "_frame"}, 32'(got), 32'(exp_f));
        chk({name, "_stable"}, glitch, 0);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sb: got byte %0h, required nothing queued", name, got[8:1]);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_sb"}, 32'(got[8:1]), 32'(e));
        end
    endtask

    initial begin
        int   n, r0, b0, len, total, guard;
        logic lvl;

        n_cmp = 0; n_err = 0; n_rd = 0; n_busy = 0;
        sys_rst        = 1'b1;
        if1.fifo_empty = 1'b1;
        if1.fifo_q     = 8'h00;
        if2.fifo_empty = 1'b1;
        if2.fifo_q     = 8'h55;

        vecs[0] = '{data: 8'h00, frame: 10'b1000000000, gap: 2};
        vecs[1] = '{data: 8'hFF, frame: 10'b1111111110, gap: 3};
        vecs[2] = '{data: 8'h3C, frame: 10'b1001111000, gap: 3};

        // Reset held 3 cycles with a byte waiting.
        push(8'hA5);
        @(posedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", tx, 1);
            chk("rst_rdreq", if1.fifo_rdreq, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        r0 = n_rd;
        b0 = n_busy;
        tick();
        chk("rel_idle_rdreq", if1.fifo_rdreq, 0);
        chk("rel_idle_busy", busy, 0);
        tick();
        chk("rel_req_rdreq", if1.fifo_rdreq, 1);
        chk("rel_req_busy", busy, 1);
        tick();
        chk("fetch_rdreq", if1.fifo_rdreq, 0);
        chk("fetch_tx", tx, 1);

        // Single byte A5.
        wait_start(n, "a5");
        chk("a5_lead", n, 0);
        run_frame(10'b1101001010, "a5");
        tick();
        chk("a5_idle_busy", busy, 0);
        chk("a5_busy_len", n_busy - b0, 42);
        chk("a5_rd_pulses", n_rd - r0, 1);

        // Back-to-back bytes from the table.
        r0 = n_rd;
        for (int i = 0; i < 3; i++) push(vecs[i].data);
        for (int i = 0; i < 3; i++) begin
            wait_start(n, "b2b");
            chk("b2b_gap", n, vecs[i].gap);
            run_frame(vecs[i].frame, "b2b");
        end
        chk("b2b_rd_pulses", n_rd - r0, 3);

        // Empty hold-off.
        r0 = n_rd;
        b0 = n_busy;
        for (int i = 0; i < 100; i++) tick();
        chk("empty_rd", n_rd - r0, 0);
        chk("empty_busy", n_busy - b0, 0);
        push(8'h81);
        tick();
        chk("holdoff_req", if1.fifo_rdreq, 1);
        tick();
        wait_start(n, "h81");
        chk("h81_lead", n, 0);
        run_frame(10'b1100000010, "h81");

        // Reset during DATA bit 3 of 07 with C3 queued behind it.
        push(8'h07);
        push(8'hC3);
        wait_start(n, "mid");
        for (int k = 1; k <= 17; k++) tick();
        chk("mid_pre_tx", tx, 0);
        sys_rst = 1'b1;
        tick();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdreq", if1.fifo_rdreq, 0);
        void'(sb_q.pop_front());
        tick();
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        wait_start(n, "c3");
        run_frame(10'b1110000110, "c3");
        chk("sb_drained", sb_q.size(), 0);

        // Default baud: one 8'h55 frame, alternating bits.
        if2.fifo_empty = 1'b0;
        n = 0;
        tick();
        while (tx2 !== 1'b0 && n < 20) begin
            n++;
            tick();
        end
        chk("def_start_seen", tx2, 0);
        lvl   = 1'b0;
        len   = 1;
        total = 0;
        for (int s = 0; s < 10; s++) begin
            guard = 0;
            forever begin
                tick();
                if (s < 9) begin
                    if (tx2 !== lvl) break;
                end else begin
                    if (busy2 !== 1'b1) break;
                end
                len++;
                guard++;
                if (guard > 6000) break;
            end
            chk("def_bit_len", len, 5208);
            total += len;
            len = 1;
            lvl = ~lvl;
        end
        chk("def_frame_len", total, 52080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_fifo_uart_tx
